bus_interconnect_nport: RTL
===========================

Name: bus_interconnect_nport

Overview:
- Parametrised successor to the fixed three-target SoC bus decoder.
- Routes the CPU native memory bus (valid/ready/addr/wdata/wstrb/rdata) to NUM_SLAVES targets through base/mask windows.
- Registers the request and response, so every transaction has a fixed one-cycle issue stage.
- Returns error responses with ready and ERR_DATA, and never hangs, for three cases: unmapped addresses, writes to read-only windows, and targets that exceed a response timeout.

Parameters:
NUM_SLAVES, 3, number of target ports (1..8)
SLV_BASE, {32'h10000000,32'h00010000,32'h00000000}, flat NUM_SLAVES*32 vector; slice i is the base of target i
SLV_MASK, {32'hFFFFFC00,32'hFFFFC000,32'hFFFFC000}, flat NUM_SLAVES*32; target i is hit when (addr & MASK_i) == BASE_i
SLV_RO, 3'b001, bit i set means target i is read-only
TIMEOUT_CYCLES, 256, maximum cycles waiting for a target's ready; 0 disables the timeout
ERR_DATA, 32'hDEADBEEF, rdata returned on any error response

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_mem_valid  in  1  request valid; held until cpu_mem_ready
cpu_mem_ready  out  1  one-cycle response strobe
cpu_mem_addr  in  32  byte address
cpu_mem_wdata  in  32  write data
cpu_mem_wstrb  in  4  byte strobes; 0 means read
cpu_mem_rdata  out  32  read data, valid while cpu_mem_ready=1
cpu_mem_instr  in  1  instruction fetch; forwarded unchanged
s_mem_valid  out  NUM_SLAVES  one-hot target request
s_mem_ready  in  NUM_SLAVES  target ready
s_mem_addr  out  32  latched address, shared by all targets
s_mem_wdata  out  32  latched write data
s_mem_wstrb  out  4  latched strobes
s_mem_instr  out  1  latched instr flag
s_mem_rdata  in  NUM_SLAVES*32  flat target read data
bus_err  out  1  one-cycle pulse, coincident with an error response
err_cause  out  2  cause of the last error: 0 none, 1 unmapped, 2 RO write, 3 timeout (sticky)
err_addr  out  32  address of the last error (sticky)
err_count  out  16  saturating error counter

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. The following outputs and registers are 0: all outputs, latched request registers, timeout counter.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - If cpu_mem_valid=1, latch addr, wdata, wstrb and instr into the s_mem_* registers.
  - Decode: sel = the lowest index i that hits. Overlapping windows resolve to the lowest index.
  - No hit: go to ERR with cause 1.
  - Hit, SLV_RO[sel]=1 and wstrb!=0: go to ERR with cause 2. No target valid is raised.
  - Otherwise go to ACCESS.
- ACCESS:
  - s_mem_valid[sel]=1; all other bits 0. The timeout counter increments every cycle.
  - When s_mem_ready[sel]=1, capture that target's rdata slice and go to RESP. s_mem_valid drops on the next cycle.
  - Ready on a non-selected target is ignored.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ready, go to ERR with cause 3. The target valid drops.
  - When timeout and ready occur in the same cycle, ready wins.
- RESP: cpu_mem_ready=1 and cpu_mem_rdata = captured data for exactly one cycle; then IDLE. For writes, rdata is the captured target data and is don't-care for the CPU.
- ERR: cpu_mem_ready=1, cpu_mem_rdata=ERR_DATA, bus_err=1 for one cycle. err_cause and err_addr are updated and err_count increments, saturating at 16'hFFFF. Then IDLE.
- Latency:
  - Target that answers ready in its first valid cycle: request in cycle 0, s_mem_valid in cycle 1, cpu_mem_ready in cycle 2.
  - Error detected at decode: cpu_mem_ready in cycle 1.
  - Timeout: cpu_mem_ready TIMEOUT_CYCLES+1 cycles after the request.
- Back-to-back: IDLE accepts a new request on the cycle after RESP/ERR. The CPU deasserts or changes valid on the edge where it samples ready.
- Transaction isolation: cpu_mem_* inputs are ignored outside IDLE, and s_mem_* outputs are stable for the whole transaction.
- Reset mid-transaction: returns to IDLE next edge and drops s_mem_valid with no response. The err_* registers are also cleared.
- Only one transaction is outstanding at a time; there is no pipelining of requests.

Decomposition:
- Shared package bus_pkg holds:
  - localparams: the state encodings; the ERR_CAUSE_NONE/UNMAPPED/RO/TIMEOUT codes; the default SoC map constants (ROM/RAM/ACCEL base and mask).
  - a function computing counter width, clog2(TIMEOUT_CYCLES+1).
- One sub-module, bus_addr_decode: purely combinational. Inputs are addr and the parameters; outputs are hit and sel_idx (a priority encoder over the mask compares). The FSM, latches and error logic live in the top.

Test Plan:
- Read ROM 0x00000100 with the target answering ready on its first valid cycle and rdata 0x12345678 -> s_mem_valid=3'b001 in cycle 1; cpu_mem_ready in cycle 2 with rdata 0x12345678; bus_err=0.
- Write 0xCAFEF00D, wstrb 4'hF, to RAM 0x00010010, with ready delayed 5 cycles -> s_mem_valid[1] held 6 cycles with wdata stable; one cpu_mem_ready; err_count=0.
- Read unmapped 0x20000000 -> cpu_mem_ready in cycle 1 with rdata 0xDEADBEEF; bus_err pulse; err_cause=1; err_addr=0x20000000; no s_mem_valid bit ever set.
- Write to ROM 0x00000004 -> cause 2 error response; s_mem_valid stays 0; err_count increments to 1.
- Accel 0x10000000 never ready, TIMEOUT_CYCLES=8 -> ready with 0xDEADBEEF 9 cycles after the request; err_cause=3; valid deasserted. A following RAM read completes normally.
- rst asserted in the 3rd cycle of a stalled ACCESS -> next cycle all outputs 0 and the FSM in IDLE. A new read is then serviced with the latency from the first scenario.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings, default SoC map and sizing helpers for the bus interconnect
package bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [1:0] ERR_CAUSE_NONE     = 2'd0;
  localparam logic [1:0] ERR_CAUSE_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_CAUSE_RO       = 2'd2;
  localparam logic [1:0] ERR_CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK   = 32'hFFFF_C000;
  localparam logic [31:0] RAM_BASE   = 32'h0001_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_C000;
  localparam logic [31:0] ACCEL_BASE = 32'h1000_0000;
  localparam logic [31:0] ACCEL_MASK = 32'hFFFF_FC00;

  // Never narrower than one bit so a disabled timeout still yields a legal vector.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - base/mask window compare with lowest-index priority
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {ACCEL_BASE, RAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {ACCEL_MASK, RAM_MASK, ROM_MASK},
  localparam int                      IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] sel_idx
);

  // Scanning downward lets the lowest matching window overwrite any higher one.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect_nport.sv
// rtl/bus_interconnect_nport.sv - registered CPU-to-N-target bus router with error responses
module bus_interconnect_nport
  import bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = {ACCEL_BASE, RAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = {ACCEL_MASK, RAM_MASK, ROM_MASK},
  parameter logic [NUM_SLAVES-1:0]    SLV_RO         = 3'b001,
  parameter int                       TIMEOUT_CYCLES = 256,
  parameter logic [31:0]              ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_mem_valid,
  output logic                       cpu_mem_ready,
  input  logic [31:0]                cpu_mem_addr,
  input  logic [31:0]                cpu_mem_wdata,
  input  logic [3:0]                 cpu_mem_wstrb,
  output logic [31:0]                cpu_mem_rdata,
  input  logic                       cpu_mem_instr,
  output logic [NUM_SLAVES-1:0]      s_mem_valid,
  input  logic [NUM_SLAVES-1:0]      s_mem_ready,
  output logic [31:0]                s_mem_addr,
  output logic [31:0]                s_mem_wdata,
  output logic [3:0]                 s_mem_wstrb,
  output logic                       s_mem_instr,
  input  logic [NUM_SLAVES*32-1:0]   s_mem_rdata,
  output logic                       bus_err,
  output logic [1:0]                 err_cause,
  output logic [31:0]                err_addr,
  output logic [15:0]                err_count
);

  localparam int             IDX_W   = idx_width(NUM_SLAVES);
  localparam int             TCW     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TO_LAST = TCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             instr_q, instr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [TCW-1:0]   cnt_q, cnt_d;
  logic [1:0]       err_cause_q, err_cause_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [15:0]      err_count_q, err_count_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_sel;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             err_set;
  logic [1:0]       err_new;
  logic [31:0]      err_at;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr    (cpu_mem_addr),
    .hit     (dec_hit),
    .sel_idx (dec_sel)
  );

  // Only the latched target is looked at; ready from any other port is ignored.
  always_comb begin
    sel_ready   = 1'b0;
    sel_rdata   = '0;
    s_mem_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready      = s_mem_ready[i];
        sel_rdata      = s_mem_rdata[32*i +: 32];
        s_mem_valid[i] = (state_q == ST_ACCESS);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    err_set     = 1'b0;
    err_new     = ERR_CAUSE_NONE;
    err_at      = addr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cpu_mem_valid) begin
          addr_d  = cpu_mem_addr;
          wdata_d = cpu_mem_wdata;
          wstrb_d = cpu_mem_wstrb;
          instr_d = cpu_mem_instr;
          sel_d   = dec_sel;
          err_at  = cpu_mem_addr;
          if (!dec_hit) begin
            state_d = ST_ERR;
            err_set = 1'b1;
            err_new = ERR_CAUSE_UNMAPPED;
          end else if (SLV_RO[dec_sel] && (cpu_mem_wstrb != 4'h0)) begin
            state_d = ST_ERR;
            err_set = 1'b1;
            err_new = ERR_CAUSE_RO;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + TCW'(1);
        // A ready arriving on the final timeout cycle still completes normally.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d = ST_ERR;
          err_set = 1'b1;
          err_new = ERR_CAUSE_TIMEOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (err_set) begin
      err_cause_d = err_new;
      err_addr_d  = err_at;
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      sel_q       <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      err_cause_q <= ERR_CAUSE_NONE;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      instr_q     <= instr_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign cpu_mem_ready = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign cpu_mem_rdata = (state_q == ST_RESP) ? rdata_q :
                         (state_q == ST_ERR)  ? ERR_DATA : 32'h0;
  assign bus_err       = (state_q == ST_ERR);
  assign s_mem_addr    = addr_q;
  assign s_mem_wdata   = wdata_q;
  assign s_mem_wstrb   = wstrb_q;
  assign s_mem_instr   = instr_q;
  assign err_cause     = err_cause_q;
  assign err_addr      = err_addr_q;
  assign err_count     = err_count_q;

endmodule
